// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch handshake between the PC sequencer and instruction memory.
// Latency: wires only. Backpressure: memory holds imem_rdy low to stretch a request.
// Ports: imem_req (fetch valid), imem_addr (fetch address), imem_rdy (memory accepts).
interface pc_sequencer_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rdy;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdy
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdy
  );
endinterface

// File: rtl/pc_sequencer.sv
// Owns the core PC: sequential fetch, branch evaluation/redirect, stall and halt handling.
// Latency: pc/flush/halted update one clk after the deciding cycle; imem_req/imem_addr are combinational.
// Backpressure: imem_rdy low holds the outstanding request; stall only blocks new fetches in RUN.
// Ports: clk, rst (sync, active high); imem (master side of the fetch handshake);
//        stall; br_valid/br_cond/br_imm/br_pc/flags (PC-relative branch); br_reg_en/br_reg_tgt
//        (register jump); halt; pc, flush, halted (registered outputs).
module pc_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                  clk,
  input  logic                  rst,
  pc_sequencer_if.master        imem,
  input  logic                  stall,
  input  logic                  br_valid,
  input  logic [2:0]            br_cond,
  input  logic [8:0]            br_imm,
  input  logic [15:0]           br_pc,
  input  logic [2:0]            flags,
  input  logic                  br_reg_en,
  input  logic [15:0]           br_reg_tgt,
  input  logic                  halt,
  output logic [15:0]           pc,
  output logic                  flush,
  output logic                  halted
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    WAIT    = 2'd1,
    WAIT_RD = 2'd2,
    HALTED  = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] pc_nxt;
  logic [15:0] rd_tgt, rd_tgt_nxt;      // redirect target parked while a fetch is outstanding
  logic        halt_pend, halt_pend_nxt; // halt seen while waiting on rdy
  logic        flush_nxt;
  logic        fetch_req;

  logic        flag_z, flag_v, flag_n;
  logic        taken;
  logic        redirect;
  logic [15:0] rel_tgt;
  logic [15:0] tgt;

  assign flag_z = flags[2];
  assign flag_v = flags[1];
  assign flag_n = flags[0];

  always_comb begin
    taken = 1'b0;
    unique case (br_cond)
      3'b000: taken = ~flag_z;
      3'b001: taken = flag_z;
      3'b010: taken = ~flag_z & ~flag_n;
      3'b011: taken = flag_n;
      3'b100: taken = flag_z | (~flag_z & ~flag_n);
      3'b101: taken = flag_z | flag_n;
      3'b110: taken = flag_v;
      3'b111: taken = 1'b1;
    endcase
  end

  // Offset is relative to the instruction after the branch; sum wraps modulo 2^16.
  assign rel_tgt  = br_pc + 16'd2 + {{7{br_imm[8]}}, br_imm};
  assign redirect = br_reg_en | (br_valid & taken);
  assign tgt      = br_reg_en ? br_reg_tgt : rel_tgt;

  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    rd_tgt_nxt    = rd_tgt;
    halt_pend_nxt = halt_pend;
    flush_nxt     = 1'b0;
    fetch_req     = 1'b0;

    unique case (state)
      RUN: begin
        fetch_req = ~stall;
        if (redirect) begin
          if (fetch_req && !imem.imem_rdy) begin
            // Cannot withdraw the request; park the target until it completes.
            rd_tgt_nxt = tgt;
            state_nxt  = WAIT_RD;
          end else begin
            // A same-cycle completed fetch is discarded in favour of the redirect.
            pc_nxt    = tgt;
            flush_nxt = 1'b1;
          end
        end else if (halt) begin
          state_nxt = HALTED;
        end else if (fetch_req && imem.imem_rdy) begin
          pc_nxt = pc + 16'd2;
        end else if (fetch_req) begin
          halt_pend_nxt = 1'b0;
          state_nxt     = WAIT;
        end
      end

      WAIT: begin
        fetch_req = 1'b1;
        if (redirect) begin
          if (imem.imem_rdy) begin
            pc_nxt    = tgt;
            flush_nxt = 1'b1;
            state_nxt = RUN;
          end else begin
            rd_tgt_nxt = tgt;
            state_nxt  = WAIT_RD;
          end
        end else if (imem.imem_rdy) begin
          if (halt || halt_pend) begin
            state_nxt = HALTED;
          end else begin
            pc_nxt    = pc + 16'd2;
            state_nxt = RUN;
          end
        end else if (halt) begin
          halt_pend_nxt = 1'b1;
        end
      end

      WAIT_RD: begin
        // halt here is in the shadow of the pending redirect and is dropped.
        fetch_req = 1'b1;
        if (imem.imem_rdy) begin
          pc_nxt    = redirect ? tgt : rd_tgt;
          flush_nxt = 1'b1;
          state_nxt = RUN;
        end else if (redirect) begin
          rd_tgt_nxt = tgt;
        end
      end

      HALTED: begin
        fetch_req = 1'b0;
      end
    endcase
  end

  assign imem.imem_req  = fetch_req & ~rst;
  assign imem.imem_addr = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      pc        <= RESET_PC;
      rd_tgt    <= 16'h0000;
      halt_pend <= 1'b0;
      flush     <= 1'b0;
      halted    <= 1'b0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      rd_tgt    <= rd_tgt_nxt;
      halt_pend <= halt_pend_nxt;
      flush     <= flush_nxt;
      halted    <= (state_nxt == HALTED);
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: sequential fetch, branch conditions, wrap, priority,
// fetch wait with redirect, stall, halt and reset recovery.
module tb_pc_sequencer;
  logic        clk;
  logic        rst;
  logic        stall;
  logic        br_valid;
  logic [2:0]  br_cond;
  logic [8:0]  br_imm;
  logic [15:0] br_pc;
  logic [2:0]  flags;
  logic        br_reg_en;
  logic [15:0] br_reg_tgt;
  logic        halt;
  logic [15:0] pc;
  logic        flush;
  logic        halted;

  pc_sequencer_if imem_bus ();

  pc_sequencer #(.RESET_PC(16'h0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem       (imem_bus.master),
    .stall      (stall),
    .br_valid   (br_valid),
    .br_cond    (br_cond),
    .br_imm     (br_imm),
    .br_pc      (br_pc),
    .flags      (flags),
    .br_reg_en  (br_reg_en),
    .br_reg_tgt (br_reg_tgt),
    .halt       (halt),
    .pc         (pc),
    .flush      (flush),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_br();
    br_valid   = 1'b0;
    br_cond    = 3'b000;
    br_imm     = 9'h000;
    br_pc      = 16'h0000;
    flags      = 3'b000;
    br_reg_en  = 1'b0;
    br_reg_tgt = 16'h0000;
  endtask

  task automatic set_br(input logic [2:0] c, input logic [2:0] f, input logic [15:0] bpc,
                        input logic [8:0] imm);
    br_valid = 1'b1;
    br_cond  = c;
    flags    = f;
    br_pc    = bpc;
    br_imm   = imm;
  endtask

  task automatic jump_to(input logic [15:0] t);
    br_reg_en  = 1'b1;
    br_reg_tgt = t;
    tick();
    clear_br();
  endtask

  // Condition vectors: flags are {Z,V,N}; taken column is hand-evaluated.
  logic [2:0] cv_cond  [9] = '{3'b000, 3'b010, 3'b011, 3'b100, 3'b100, 3'b101, 3'b110, 3'b110, 3'b000};
  logic [2:0] cv_flags [9] = '{3'b000, 3'b001, 3'b001, 3'b000, 3'b001, 3'b001, 3'b010, 3'b000, 3'b100};
  logic       cv_taken [9] = '{1'b1,   1'b0,   1'b1,   1'b1,   1'b0,   1'b1,   1'b1,   1'b0,   1'b0};

  logic [15:0] exp_pc;

  initial begin
    rst      = 1'b1;
    stall    = 1'b0;
    halt     = 1'b0;
    imem_bus.imem_rdy = 1'b0;
    clear_br();
    tick();
    tick();
    check("rst_pc", pc, 16'h0000);
    check("rst_flush", 16'(flush), 16'h0000);
    check("rst_halted", 16'(halted), 16'h0000);
    check("rst_req", 16'(imem_bus.imem_req), 16'h0000);

    rst = 1'b0;
    imem_bus.imem_rdy = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("seq_addr", imem_bus.imem_addr, 16'(i * 2));
      check("seq_req", 16'(imem_bus.imem_req), 16'h0001);
      check("seq_flush", 16'(flush), 16'h0000);
      tick();
    end

    // Z=1 with cond 001: 0010 + 2 + 4 = 0016
    set_br(3'b001, 3'b100, 16'h0010, 9'h004);
    tick();
    clear_br();
    check("beq_pc", pc, 16'h0016);
    check("beq_flush", 16'(flush), 16'h0001);
    tick();
    check("beq_next_pc", pc, 16'h0018);
    check("beq_flush_drop", 16'(flush), 16'h0000);

    set_br(3'b001, 3'b000, 16'h0010, 9'h004);
    tick();
    clear_br();
    check("beq_nt_pc", pc, 16'h001A);
    check("beq_nt_flush", 16'(flush), 16'h0000);

    // Target for all vectors: 0100 + 2 + 0x10 = 0112
    exp_pc = 16'h001A;
    for (int i = 0; i < 9; i++) begin
      set_br(cv_cond[i], cv_flags[i], 16'h0100, 9'h010);
      tick();
      clear_br();
      exp_pc = cv_taken[i] ? 16'h0112 : exp_pc + 16'd2;
      check($sformatf("cond%0d_pc", i), pc, exp_pc);
      check($sformatf("cond%0d_flush", i), 16'(flush), 16'(cv_taken[i]));
    end

    // 0000 + 2 - 4 wraps to FFFE
    set_br(3'b111, 3'b000, 16'h0000, 9'h1FC);
    tick();
    clear_br();
    check("wrap_pc", pc, 16'hFFFE);

    // Register jump beats a taken PC-relative branch (which would go to 0002).
    set_br(3'b111, 3'b000, 16'h0000, 9'h000);
    br_reg_en  = 1'b1;
    br_reg_tgt = 16'h1234;
    tick();
    clear_br();
    check("prio_pc", pc, 16'h1234);
    check("prio_flush", 16'(flush), 16'h0001);

    // Fetch held for 3 cycles at 0008, redirect to 0040 arrives in the 2nd.
    jump_to(16'h0008);
    imem_bus.imem_rdy = 1'b0;
    #1;
    check("w1_addr", imem_bus.imem_addr, 16'h0008);
    check("w1_req", 16'(imem_bus.imem_req), 16'h0001);
    tick();
    check("w1_flush", 16'(flush), 16'h0000);
    br_reg_en  = 1'b1;
    br_reg_tgt = 16'h0040;
    #1;
    check("w2_addr", imem_bus.imem_addr, 16'h0008);
    tick();
    clear_br();
    check("w3_addr", imem_bus.imem_addr, 16'h0008);
    check("w3_req", 16'(imem_bus.imem_req), 16'h0001);
    check("w3_flush", 16'(flush), 16'h0000);
    tick();
    imem_bus.imem_rdy = 1'b1;
    #1;
    check("w4_addr", imem_bus.imem_addr, 16'h0008);
    check("w4_flush", 16'(flush), 16'h0000);
    tick();
    check("wrd_pc", pc, 16'h0040);
    check("wrd_flush", 16'(flush), 16'h0001);
    tick();
    check("wrd_next_pc", pc, 16'h0042);
    check("wrd_flush_drop", 16'(flush), 16'h0000);

    // Plain wait: stall cannot withdraw an outstanding request.
    imem_bus.imem_rdy = 1'b0;
    tick();
    stall = 1'b1;
    #1;
    check("wait_stall_req", 16'(imem_bus.imem_req), 16'h0001);
    check("wait_stall_addr", imem_bus.imem_addr, 16'h0042);
    imem_bus.imem_rdy = 1'b1;
    tick();
    check("wait_done_pc", pc, 16'h0044);
    stall = 1'b0;

    // Stall in RUN at 0004.
    jump_to(16'h0004);
    stall = 1'b1;
    #1;
    check("stall_req0", 16'(imem_bus.imem_req), 16'h0000);
    tick();
    check("stall_pc1", pc, 16'h0004);
    check("stall_req1", 16'(imem_bus.imem_req), 16'h0000);
    tick();
    check("stall_pc2", pc, 16'h0004);
    stall = 1'b0;
    #1;
    check("unstall_req", 16'(imem_bus.imem_req), 16'h0001);
    check("unstall_addr", imem_bus.imem_addr, 16'h0004);
    tick();
    check("unstall_pc", pc, 16'h0006);

    // Halt at 0020, then branches are ignored.
    jump_to(16'h0020);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check("halt_halted", 16'(halted), 16'h0001);
    check("halt_req", 16'(imem_bus.imem_req), 16'h0000);
    check("halt_pc", pc, 16'h0020);
    for (int i = 0; i < 10; i++) begin
      set_br(3'b111, 3'b000, 16'h0100, 9'h010);
      br_reg_en  = 1'b1;
      br_reg_tgt = 16'h1111;
      tick();
      check("hold_pc", pc, 16'h0020);
      check("hold_flush", 16'(flush), 16'h0000);
      check("hold_halted", 16'(halted), 16'h0001);
    end
    clear_br();

    rst = 1'b1;
    tick();
    check("rerst_pc", pc, 16'h0000);
    check("rerst_halted", 16'(halted), 16'h0000);
    check("rerst_req", 16'(imem_bus.imem_req), 16'h0000);
    rst = 1'b0;
    #1;
    check("rerun_req", 16'(imem_bus.imem_req), 16'h0001);
    check("rerun_addr", imem_bus.imem_addr, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the architectural PC register of the 16-bit core and sequences instruction fetch through a req/rdy instruction-memory handshake.
- Evaluates branch conditions against the Z/V/N flags, computes redirect targets and issues a one-cycle pipeline flush on a taken redirect.
- Handles stall from the hazard unit and halt (HLT). Sits between the decode/execute branch logic and instruction memory.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  16  fetch address; equals pc while imem_req=1.
- imem_rdy  in  1  memory accepts/completes the request this cycle.
- stall  in  1  hazard unit blocks issue of new fetches.
- br_valid  in  1  conditional/unconditional PC-relative branch resolving this cycle.
- br_cond  in  3  ccc condition code.
- br_imm  in  9  signed offset.
- br_pc  in  16  PC of the branch instruction.
- flags  in  3  {Z,V,N}: flags[2]=Z, flags[1]=V, flags[0]=N.
- br_reg_en  in  1  register-indirect jump resolving this cycle (always taken).
- br_reg_tgt  in  16  target for register-indirect jump.
- halt  in  1  HLT decoded.
- pc  out  16  current PC register.
- flush  out  1  registered; high for exactly one cycle after a redirect is applied.
- halted  out  1  registered; high in HALTED state.

Behaviour:
- Reset (rst=1 at clk edge): pc=RESET_PC, state=RUN, flush=0, halted=0. While rst=1, imem_req=0. Reset overrides everything, including mid-wait and HALTED.
- Condition evaluation (taken):
  - 000: Z=0
  - 001: Z=1
  - 010: Z=0 & N=0
  - 011: N=1
  - 100: Z=1 | (Z=0 & N=0)
  - 101: Z=1 | N=1
  - 110: V=1
  - 111: always
- Redirect event = (br_valid & taken) | br_reg_en. br_reg_en has priority over br_valid if both are asserted.
- PC-relative target = br_pc + 16'd2 + sign_extend(br_imm), modulo 2^16 (wraps, no saturation). Register target = br_reg_tgt. A not-taken br_valid has no effect.
- States:
  - RUN: imem_req = ~stall; imem_addr = pc.
  - WAIT: request outstanding; imem_req=1 and imem_addr held stable until imem_rdy.
  - WAIT_RD: request outstanding with a redirect pending.
  - HALTED: imem_req=0; pc frozen.
- RUN transitions:
  - redirect: pc<=target; flush<=1 next cycle; stay RUN. Any same-cycle req&rdy is discarded (no pc+2). If req=1 & rdy=0, go WAIT_RD holding the pending target instead.
  - else halt: go HALTED; pc holds.
  - else req & rdy: pc<=pc+2.
  - else req & ~rdy: go WAIT.
  - else (stall): pc holds.
- WAIT transitions (stall is ignored; an outstanding request is never withdrawn):
  - redirect & rdy: pc<=target; flush pulse; go RUN.
  - redirect & ~rdy: latch target; go WAIT_RD.
  - halt (no redirect): go HALTED once rdy=1, without advancing pc.
  - rdy: pc<=pc+2; go RUN.
- WAIT_RD transitions:
  - A newer redirect replaces the latched target.
  - On rdy: pc<=latched target; flush pulse; go RUN.
  - halt is ignored (it lies in the flushed shadow).
- Redirect and halt in the same cycle: redirect wins, halt is ignored.
- HALTED: all inputs ignored except rst; halted=1 from the cycle after entry.
- pc is always even in normal use; the block does not check alignment.
- flush is never asserted two cycles in a row unless two distinct redirects are applied on consecutive cycles.

Test Plan:
- Reset then imem_rdy tied 1, no branches, 4 cycles -> imem_addr 0000, 0002, 0004, 0006; flush=0.
- RUN, br_valid=1, br_cond=001, flags=3'b100, br_pc=0010, br_imm=9'h004 -> next pc=0016, flush=1 for one cycle. Repeat with flags=3'b000 -> no redirect, pc continues sequentially.
- br_cond=111, br_imm=9'h1FC (-4), br_pc=0000 -> pc=FFFE (wrap). br_reg_en=1, br_reg_tgt=1234 with br_valid taken the same cycle -> pc=1234.
- imem_rdy=0 for 3 cycles with pc=0008, redirect to 0040 in the 2nd wait cycle -> imem_addr stays 0008 until rdy. Then pc=0040, flush pulses on the cycle after rdy, never 000A.
- stall=1 for 2 cycles in RUN at pc=0004 -> imem_req=0 and pc=0004 held. After release, fetch 0004.
- halt=1 at pc=0020 -> halted=1 next cycle, imem_req=0, pc=0020 held through 10 cycles of branches. rst=1 -> pc=0000, halted=0.
